// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and state encoding for the PS/2 key controller
package ps2_pkg;
  localparam logic [7:0] BREAK_CODE_DFLT = 8'hF0;
  localparam logic [7:0] EXT_CODE_DFLT   = 8'hE0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    BRK  = 2'd2
  } ps2_state_e;

  // Set-2 scan codes exercised by the bench
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_B     = 8'h32;
  localparam logic [7:0] SC_0     = 8'h45;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_EXT_UP = 8'h75;
endpackage

// File: rtl/ps2_key_ctrl_if.sv
// rtl/ps2_key_ctrl_if.sv - FIFO handshake and decoder-facing signals of the key controller
interface ps2_key_ctrl_if;
  logic [7:0] ps2_data;
  logic       ps2_ready;
  logic       ps2_nextdata;
  logic [7:0] key_num;
  logic [7:0] asc_num;
  logic [7:0] key_times;
  logic       disp_en;

  modport master (
    output ps2_data, ps2_ready,
    input  ps2_nextdata, key_num, asc_num, key_times, disp_en
  );

  modport slave (
    input  ps2_data, ps2_ready,
    output ps2_nextdata, key_num, asc_num, key_times, disp_en
  );
endinterface

// File: rtl/ps2_ascii_rom.sv
// rtl/ps2_ascii_rom.sv - set-2 scan code to lowercase ASCII, 00 for unmapped codes
module ps2_ascii_rom
  import ps2_pkg::*;
(
  input  logic [7:0] i_code,
  output logic [7:0] o_ascii
);
  always_comb begin
    o_ascii = 8'h00;
    case (i_code)
      8'h1C: o_ascii = 8'h61; 8'h32: o_ascii = 8'h62; 8'h21: o_ascii = 8'h63;
      8'h23: o_ascii = 8'h64; 8'h24: o_ascii = 8'h65; 8'h2B: o_ascii = 8'h66;
      8'h34: o_ascii = 8'h67; 8'h33: o_ascii = 8'h68; 8'h43: o_ascii = 8'h69;
      8'h3B: o_ascii = 8'h6A; 8'h42: o_ascii = 8'h6B; 8'h4B: o_ascii = 8'h6C;
      8'h3A: o_ascii = 8'h6D; 8'h31: o_ascii = 8'h6E; 8'h44: o_ascii = 8'h6F;
      8'h4D: o_ascii = 8'h70; 8'h15: o_ascii = 8'h71; 8'h2D: o_ascii = 8'h72;
      8'h1B: o_ascii = 8'h73; 8'h2C: o_ascii = 8'h74; 8'h3C: o_ascii = 8'h75;
      8'h2A: o_ascii = 8'h76; 8'h1D: o_ascii = 8'h77; 8'h22: o_ascii = 8'h78;
      8'h35: o_ascii = 8'h79; 8'h1A: o_ascii = 8'h7A;
      8'h45: o_ascii = 8'h30; 8'h16: o_ascii = 8'h31; 8'h1E: o_ascii = 8'h32;
      8'h26: o_ascii = 8'h33; 8'h25: o_ascii = 8'h34; 8'h2E: o_ascii = 8'h35;
      8'h36: o_ascii = 8'h36; 8'h3D: o_ascii = 8'h37; 8'h3E: o_ascii = 8'h38;
      8'h46: o_ascii = 8'h39;
      8'h29: o_ascii = 8'h20;
      default: o_ascii = 8'h00;
    endcase
  end
endmodule

// File: rtl/ps2_key_ctrl.sv
// rtl/ps2_key_ctrl.sv - pops scan codes from the PS/2 FIFO and tracks make/break/extended
// sequences to drive the seven-segment decoder inputs.
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter logic [7:0] BREAK_CODE = BREAK_CODE_DFLT,
  parameter logic [7:0] EXT_CODE   = EXT_CODE_DFLT
) (
  input logic           clk,
  input logic           rst,
  ps2_key_ctrl_if.slave bus
);
  ps2_state_e r_state;
  logic       r_ext;
  logic       r_prior_held;
  logic       r_nextdata;
  logic [7:0] r_key_num;
  logic [7:0] r_asc_num;
  logic [7:0] r_key_times;
  logic       r_disp_en;

  logic       w_accept;
  logic [7:0] w_rom_ascii;
  logic [7:0] w_ascii;

  // The pop strobe itself blocks the next accept, so the FIFO has a cycle to advance
  assign w_accept = bus.ps2_ready & ~r_nextdata;
  assign w_ascii  = r_ext ? 8'h00 : w_rom_ascii;

  ps2_ascii_rom u_rom (
    .i_code  (bus.ps2_data),
    .o_ascii (w_rom_ascii)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ext        <= 1'b0;
      r_prior_held <= 1'b0;
      r_nextdata   <= 1'b0;
      r_key_num    <= 8'h00;
      r_asc_num    <= 8'h00;
      r_key_times  <= 8'h00;
      r_disp_en    <= 1'b0;
    end else begin
      r_nextdata <= w_accept;
      if (w_accept) begin
        if (bus.ps2_data == EXT_CODE) begin
          r_ext <= 1'b1;
        end else begin
          if (bus.ps2_data != BREAK_CODE) r_ext <= 1'b0;
          case (r_state)
            IDLE, HELD: begin
              if (bus.ps2_data == BREAK_CODE) begin
                r_prior_held <= (r_state == HELD);
                r_state      <= BRK;
              end else if (r_state == IDLE || bus.ps2_data != r_key_num) begin
                r_key_num   <= bus.ps2_data;
                r_asc_num   <= w_ascii;
                r_key_times <= r_key_times + 8'd1;
                r_disp_en   <= 1'b1;
                r_state     <= HELD;
              end
            end
            BRK: begin
              // Only the release of the currently held key blanks the display
              if (r_prior_held && bus.ps2_data == r_key_num) begin
                r_disp_en <= 1'b0;
                r_state   <= IDLE;
              end else begin
                r_state <= r_prior_held ? HELD : IDLE;
              end
            end
            default: r_state <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.ps2_nextdata = r_nextdata;
  assign bus.key_num      = r_key_num;
  assign bus.asc_num      = r_asc_num;
  assign bus.key_times    = r_key_times;
  assign bus.disp_en      = r_disp_en;
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb/tb_ps2_key_ctrl.sv - FIFO emulation, key-level reference model and directed scenarios
module tb_ps2_key_ctrl;
  import ps2_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_key_ctrl_if bus();

  ps2_key_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int nd_pulses = 0;
  int nd_adjacent = 0;
  bit prev_nd = 1'b0;

  logic [7:0] fifo[$];

  logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  // Key-level model: which key is down, whether a release prefix is pending
  bit         m_nd, m_ext, m_hold, m_brk, do_pop;
  logic [7:0] m_key, m_asc, m_times;

  function automatic logic [7:0] ref_ascii(logic [7:0] c);
    for (int i = 0; i < 26; i++) if (letter_sc[i] == c) return 8'h61 + 8'(i);
    for (int i = 0; i < 10; i++) if (digit_sc[i] == c) return 8'h30 + 8'(i);
    if (c == 8'h29) return 8'h20;
    return 8'h00;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_nd = 0; m_ext = 0; m_hold = 0; m_brk = 0;
    m_key = 8'h00; m_asc = 8'h00; m_times = 8'h00;
  endtask

  task automatic model_byte(logic [7:0] b);
    if (b == 8'hE0) begin
      m_ext = 1;
    end else if (m_brk) begin
      m_brk = 0;
      if (b != 8'hF0) m_ext = 0;
      if (m_hold && b == m_key) m_hold = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (!(m_hold && b == m_key)) begin
        m_key   = b;
        m_asc   = m_ext ? 8'h00 : ref_ascii(b);
        m_times = m_times + 8'd1;
        m_hold  = 1;
      end
      m_ext = 0;
    end
  endtask

  task automatic cycle(input bit r);
    bit acc;
    @(posedge clk);
    #1;
    if (do_pop && fifo.size() > 0) void'(fifo.pop_front());
    rst           = r;
    bus.ps2_ready = (fifo.size() > 0);
    bus.ps2_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
    @(negedge clk);
    chk("nextdata", {7'd0, bus.ps2_nextdata}, {7'd0, m_nd});
    chk("key_num", bus.key_num, m_key);
    chk("asc_num", bus.asc_num, m_asc);
    chk("key_times", bus.key_times, m_times);
    chk("disp_en", {7'd0, bus.disp_en}, {7'd0, m_hold});
    if (bus.ps2_nextdata) nd_pulses++;
    if (bus.ps2_nextdata && prev_nd) nd_adjacent++;
    prev_nd = bus.ps2_nextdata;
    do_pop = m_nd;
    if (rst) begin
      model_reset();
    end else begin
      acc  = bus.ps2_ready && !m_nd;
      m_nd = acc;
      if (acc) model_byte(bus.ps2_data);
    end
  endtask

  task automatic drain(int budget);
    int n = 0;
    while ((fifo.size() > 0 || m_nd || do_pop) && n < budget) begin
      cycle(1'b0);
      n++;
    end
    if (fifo.size() > 0 || m_nd || do_pop) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d expected=<%0d", n, budget);
    end
  endtask

  task automatic do_reset();
    cycle(1'b1);
    cycle(1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    bus.ps2_ready = 1'b0;
    bus.ps2_data  = 8'h00;
    model_reset();
    do_pop = 0;
    repeat (2) @(posedge clk);
    do_reset();
    chk("rst key_times", bus.key_times, 8'h00);
    chk("rst disp_en", {7'd0, bus.disp_en}, 8'h00);

    // First press
    nd_pulses = 0;
    fifo.push_back(SC_A);
    drain(20);
    chk("p1 key_num", bus.key_num, 8'h1C);
    chk("p1 asc_num", bus.asc_num, 8'h61);
    chk("p1 key_times", bus.key_times, 8'h01);
    chk("p1 disp_en", {7'd0, bus.disp_en}, 8'h01);
    chk("p1 pulses", nd_pulses[7:0], 8'd1);

    // Typematic repeats then release
    repeat (3) fifo.push_back(SC_A);
    drain(40);
    chk("p2 key_times", bus.key_times, 8'h01);
    chk("p2 disp_en", {7'd0, bus.disp_en}, 8'h01);
    fifo.push_back(8'hF0); fifo.push_back(SC_A);
    drain(40);
    chk("p2 rel disp_en", {7'd0, bus.disp_en}, 8'h00);
    chk("p2 rel key_num", bus.key_num, 8'h1C);

    // Rollover: second key pressed while first held
    do_reset();
    fifo.push_back(SC_A); fifo.push_back(SC_B);
    drain(40);
    chk("p3 key_num", bus.key_num, 8'h32);
    chk("p3 asc_num", bus.asc_num, 8'h62);
    chk("p3 key_times", bus.key_times, 8'h02);
    fifo.push_back(8'hF0); fifo.push_back(SC_A);
    drain(40);
    chk("p3 stale rel disp_en", {7'd0, bus.disp_en}, 8'h01);
    fifo.push_back(8'hF0); fifo.push_back(SC_B);
    drain(40);
    chk("p3 rel disp_en", {7'd0, bus.disp_en}, 8'h00);

    // Extended key
    do_reset();
    fifo.push_back(8'hE0); fifo.push_back(SC_EXT_UP);
    drain(40);
    chk("p4 key_num", bus.key_num, 8'h75);
    chk("p4 asc_num", bus.asc_num, 8'h00);
    chk("p4 key_times", bus.key_times, 8'h01);
    fifo.push_back(8'hE0); fifo.push_back(8'hF0); fifo.push_back(SC_EXT_UP);
    drain(40);
    chk("p4 rel disp_en", {7'd0, bus.disp_en}, 8'h00);
    fifo.push_back(SC_0);
    drain(20);
    chk("p4 ext cleared asc", bus.asc_num, 8'h30);
    chk("p4 key_times2", bus.key_times, 8'h02);

    // key_times wrap
    do_reset();
    for (int i = 0; i < 255; i++) begin
      fifo.push_back(SC_A); fifo.push_back(8'hF0); fifo.push_back(SC_A);
    end
    drain(4000);
    chk("p5 key_times ff", bus.key_times, 8'hFF);
    chk("p5 disp_en", {7'd0, bus.disp_en}, 8'h00);
    fifo.push_back(SC_1);
    drain(20);
    chk("p5 wrap key_times", bus.key_times, 8'h00);
    chk("p5 wrap asc_num", bus.asc_num, 8'h31);

    // Back-to-back queue, then reset while a break prefix is pending
    do_reset();
    nd_pulses = 0;
    nd_adjacent = 0;
    fifo.push_back(SC_0); fifo.push_back(SC_1); fifo.push_back(SC_2); fifo.push_back(8'hF0);
    drain(60);
    chk("p6 pulses", nd_pulses[7:0], 8'd4);
    chk("p6 adjacent pulses", nd_adjacent[7:0], 8'd0);
    chk("p6 key_times", bus.key_times, 8'h03);
    do_reset();
    chk("p6 rst key_num", bus.key_num, 8'h00);
    chk("p6 rst asc_num", bus.asc_num, 8'h00);
    chk("p6 rst key_times", bus.key_times, 8'h00);
    chk("p6 rst disp_en", {7'd0, bus.disp_en}, 8'h00);
    chk("p6 rst nextdata", {7'd0, bus.ps2_nextdata}, 8'h00);
    fifo.push_back(SC_A);
    drain(20);
    chk("p6 make after rst", bus.key_times, 8'h01);
    chk("p6 make disp_en", {7'd0, bus.disp_en}, 8'h01);

    repeat (3) cycle(1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
